// File: rtl/slope_adc_mc_pkg.sv
// Shared definitions for the multi-channel single-slope ADC front end.
// Holds the FSM state encoding and a helper that checks the parameter set
// for ranges the datapath can actually handle.
package slope_adc_mc_pkg;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_DISCHARGE = 2'd1;
    localparam logic [1:0] ST_MEASURE   = 2'd2;
    localparam logic [1:0] ST_PUBLISH   = 2'd3;

    // WIDTH is capped at 30 so that the 2^WIDTH-1 bound still fits a
    // signed int during elaboration.
    function automatic bit params_ok(input int channels, input int width,
                                     input int tick_div, input int discharge_ticks,
                                     input int avg_log2);
        return (channels >= 1) && (width >= 1) && (width <= 30) &&
               (tick_div >= 1) && (discharge_ticks >= 1) &&
               (discharge_ticks <= (1 << width) - 1) &&
               (avg_log2 >= 0) && (avg_log2 <= 4);
    endfunction

endpackage

// File: rtl/slope_adc_mc_if.sv
// Bus between the ADC front end and its surroundings.
//   enable    : run conversions while high
//   sense     : raw comparator outputs, one per channel, low = tripped
//   capacitor : shared RC drive, high while measuring
//   out       : packed results, channel i at [i*WIDTH +: WIDTH]
//   overrange : per-channel "never tripped in this frame"
//   valid     : one-cycle strobe when out/overrange update
// master = the side driving enable/sense, slave = the converter.
interface slope_adc_mc_if #(
    parameter int CHANNELS = 1,
    parameter int WIDTH    = 16
);
    logic                         enable;
    logic [CHANNELS-1:0]          sense;
    logic                         capacitor;
    logic [CHANNELS*WIDTH-1:0]    out;
    logic [CHANNELS-1:0]          overrange;
    logic                         valid;

    modport master (output enable, output sense,
                    input  capacitor, input out, input overrange, input valid);
    modport slave  (input  enable, input sense,
                    output capacitor, output out, output overrange, output valid);
endinterface

// File: rtl/slope_adc_mc_chan.sv
// One comparator channel of the single-slope ADC: 2-flop synchronizer,
// captured flag, capture register, frame accumulator and overrange bit.
//   osc, reset : clock and synchronous active-high reset
//   sense      : raw asynchronous comparator output (low = tripped)
//   start      : clear flag and capture (entering MEASURE)
//   sample     : a MEASURE tick, compare synced sense against count
//   finish     : the MEASURE tick that ends the conversion
//   last       : the ending conversion is the last of its frame
//   discard    : drop the partial frame (enable fell)
//   count      : shared tick counter
//   done       : channel is (or becomes this tick) captured
//   acc_sum    : accumulator plus this conversion's final capture
//   ovr_frame  : frame overrange including this conversion
module slope_adc_chan
    import slope_adc_mc_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int AVG_LOG2 = 0
) (
    input  logic                      osc,
    input  logic                      reset,
    input  logic                      sense,
    input  logic                      start,
    input  logic                      sample,
    input  logic                      finish,
    input  logic                      last,
    input  logic                      discard,
    input  logic [WIDTH-1:0]          count,
    output logic                      done,
    output logic [WIDTH+AVG_LOG2-1:0] acc_sum,
    output logic                      ovr_frame
);

    localparam int AW = WIDTH + AVG_LOG2;

    logic             sync1, sync2;
    logic             flag;
    logic             hit, miss;
    logic [WIDTH-1:0] capture, cap_next;
    logic [AW-1:0]    acc;
    logic             ovr;

    // Synchronizer idles high so a reset never looks like a trip.
    always_ff @(posedge osc) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= sense;
            sync2 <= sync1;
        end
    end

    // cap_next is the value this conversion settles on at this edge, so the
    // accumulator and the published result can use it without a stall.
    assign hit       = sample & ~flag & ~sync2;
    assign miss      = finish & ~flag & ~hit;
    assign done      = flag | hit;
    assign cap_next  = hit ? count : (miss ? {WIDTH{1'b1}} : capture);
    assign acc_sum   = acc + AW'(cap_next);
    assign ovr_frame = ovr | miss;

    always_ff @(posedge osc) begin
        if (reset) begin
            flag    <= 1'b0;
            capture <= '0;
            acc     <= '0;
            ovr     <= 1'b0;
        end else begin
            if (start) begin
                flag    <= 1'b0;
                capture <= '0;
            end else if (sample) begin
                flag    <= done;
                capture <= cap_next;
            end
            if (discard) begin
                acc <= '0;
                ovr <= 1'b0;
            end else if (finish) begin
                acc <= last ? '0 : acc_sum;
                ovr <= last ? 1'b0 : ovr_frame;
            end
        end
    end

endmodule

// File: rtl/slope_adc_mc.sv
// Multi-channel single-slope ADC front end. Drives the shared RC capacitor,
// times each channel's comparator trip against a common tick counter,
// averages 2^AVG_LOG2 conversions and publishes a frame with a valid pulse.
//   osc   : system clock
//   reset : synchronous active-high reset
//   bus   : slave side of slope_adc_mc_if (enable, sense in; capacitor,
//           out, overrange, valid out)
module slope_adc_mc
    import slope_adc_mc_pkg::*;
#(
    parameter int CHANNELS        = 1,
    parameter int WIDTH           = 16,
    parameter int TICK_DIV        = 8,
    parameter int DISCHARGE_TICKS = 65535,
    parameter int AVG_LOG2        = 0
) (
    input logic           osc,
    input logic           reset,
    slope_adc_mc_if.slave bus
);

    localparam int               AW        = WIDTH + AVG_LOG2;
    localparam int               TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [WIDTH-1:0] COUNT_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] DIS_LAST  = WIDTH'(DISCHARGE_TICKS - 1);
    localparam logic [4:0]       IDX_LAST  = 5'((1 << AVG_LOG2) - 1);

    if (!params_ok(CHANNELS, WIDTH, TICK_DIV, DISCHARGE_TICKS, AVG_LOG2)) begin : g_param_check
        $error("slope_adc_mc: parameter out of range");
    end

    logic [1:0]                   state;
    logic [TW-1:0]                tick_cnt;
    logic                         tick;
    logic [WIDTH-1:0]             count;
    logic [4:0]                   idx;
    logic                         start, sample, finish, discard, last;
    logic [CHANNELS-1:0]          done;
    logic [CHANNELS-1:0]          ovr_frame;
    logic [AW-1:0]                acc_sum [CHANNELS];
    logic [CHANNELS*WIDTH-1:0]    out_r;
    logic [CHANNELS-1:0]          ovr_r;
    logic                         valid_r;

    assign tick    = (tick_cnt == TICK_LAST);
    assign start   = (state == ST_DISCHARGE) && bus.enable && tick && (count == DIS_LAST);
    assign sample  = (state == ST_MEASURE) && bus.enable && tick;
    // The count==max test makes the measure window end before count wraps.
    assign finish  = sample && ((&done) || (count == COUNT_MAX));
    assign discard = ((state == ST_DISCHARGE) || (state == ST_MEASURE)) && !bus.enable;
    assign last    = (idx == IDX_LAST);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        slope_adc_chan #(
            .WIDTH    (WIDTH),
            .AVG_LOG2 (AVG_LOG2)
        ) u_chan (
            .osc       (osc),
            .reset     (reset),
            .sense     (bus.sense[i]),
            .start     (start),
            .sample    (sample),
            .finish    (finish),
            .last      (last),
            .discard   (discard),
            .count     (count),
            .done      (done[i]),
            .acc_sum   (acc_sum[i]),
            .ovr_frame (ovr_frame[i])
        );
    end

    // Prescaler idles at zero so every conversion starts with a full tick.
    always_ff @(posedge osc) begin
        if (reset || (state == ST_IDLE)) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    // count doubles as the discharge tick counter and the measure timer.
    // Results are registered on the final MEASURE tick so valid is high
    // during the PUBLISH cycle itself.
    always_ff @(posedge osc) begin
        if (reset) begin
            state   <= ST_IDLE;
            count   <= '0;
            idx     <= '0;
            out_r   <= '0;
            ovr_r   <= '0;
            valid_r <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.enable) begin
                        state <= ST_DISCHARGE;
                        count <= '0;
                    end
                end
                ST_DISCHARGE: begin
                    if (!bus.enable) begin
                        state <= ST_IDLE;
                        idx   <= '0;
                    end else if (start) begin
                        state <= ST_MEASURE;
                        count <= '0;
                    end else if (tick) begin
                        count <= count + WIDTH'(1);
                    end
                end
                ST_MEASURE: begin
                    if (!bus.enable) begin
                        state <= ST_IDLE;
                        idx   <= '0;
                    end else if (finish) begin
                        state <= ST_PUBLISH;
                        if (last) begin
                            idx     <= '0;
                            valid_r <= 1'b1;
                            ovr_r   <= ovr_frame;
                            for (int i = 0; i < CHANNELS; i++) begin
                                out_r[i*WIDTH +: WIDTH] <= acc_sum[i][AVG_LOG2 +: WIDTH];
                            end
                        end else begin
                            idx <= idx + 5'd1;
                        end
                    end else if (tick) begin
                        count <= count + WIDTH'(1);
                    end
                end
                ST_PUBLISH: begin
                    state <= bus.enable ? ST_DISCHARGE : ST_IDLE;
                    count <= '0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.capacitor = (state == ST_MEASURE);
    assign bus.out       = out_r;
    assign bus.overrange = ovr_r;
    assign bus.valid     = valid_r;

endmodule

// File: tb/tb_slope_adc_mc.sv
// Directed bench for slope_adc_mc: a plain instance (dut_a) for single
// conversions, disable and reset, and an averaging instance (dut_b).
// Trip points are given in MEASURE ticks; the sense drivers time them from
// the capacitor rising edge so the synced sense falls exactly at that tick.
module tb_slope_adc_mc;

    logic osc;
    logic reset;

    int checks   = 0;
    int failures = 0;

    int trip_a [2] = '{-1, -1};
    int trip_b [2] = '{-1, -1};
    int mcyc_a = 0, meas_len_a = 0, conv_cnt_a = 0, valid_cnt_a = 0;
    int mcyc_b = 0, meas_len_b = 0, conv_cnt_b = 0, valid_cnt_b = 0;

    typedef struct {
        int trip0;
        int trip1;
        int exp0;
        int exp1;
        int exp_ovr;
        int exp_len;
    } vec_t;

    typedef struct {
        int t0 [4];
        int t1 [4];
        int exp0;
        int exp1;
        int exp_ovr;
    } frame_t;

    vec_t   vecs   [8];
    frame_t frames [3];

    slope_adc_mc_if #(.CHANNELS(2), .WIDTH(8)) bus_a ();
    slope_adc_mc_if #(.CHANNELS(2), .WIDTH(8)) bus_b ();

    slope_adc_mc #(
        .CHANNELS(2), .WIDTH(8), .TICK_DIV(2), .DISCHARGE_TICKS(4), .AVG_LOG2(0)
    ) dut_a (
        .osc   (osc),
        .reset (reset),
        .bus   (bus_a)
    );

    slope_adc_mc #(
        .CHANNELS(2), .WIDTH(8), .TICK_DIV(2), .DISCHARGE_TICKS(4), .AVG_LOG2(2)
    ) dut_b (
        .osc   (osc),
        .reset (reset),
        .bus   (bus_b)
    );

    initial begin
        osc = 1'b0;
        forever #5 osc = ~osc;
    end

    // mcyc = (cycles since capacitor rose) + 1; sense of channel i goes low
    // once mcyc reaches 2*trip, which makes the synced sense low first on
    // MEASURE tick 'trip' (TICK_DIV=2). Also counts valid pulses and
    // records the capacitor-high length of each finished conversion.
    initial begin
        bus_a.sense = 2'b11;
        forever begin
            @(posedge osc);
            #1;
            if (bus_a.valid === 1'b1) valid_cnt_a++;
            if (bus_a.capacitor === 1'b1) begin
                mcyc_a++;
            end else begin
                if (mcyc_a > 0) begin
                    meas_len_a = mcyc_a;
                    conv_cnt_a++;
                end
                mcyc_a = 0;
            end
            for (int i = 0; i < 2; i++)
                bus_a.sense[i] = (trip_a[i] >= 0 && mcyc_a >= 2 * trip_a[i]) ? 1'b0 : 1'b1;
        end
    end

    initial begin
        bus_b.sense = 2'b11;
        forever begin
            @(posedge osc);
            #1;
            if (bus_b.valid === 1'b1) valid_cnt_b++;
            if (bus_b.capacitor === 1'b1) begin
                mcyc_b++;
            end else begin
                if (mcyc_b > 0) begin
                    meas_len_b = mcyc_b;
                    conv_cnt_b++;
                end
                mcyc_b = 0;
            end
            for (int i = 0; i < 2; i++)
                bus_b.sense[i] = (trip_b[i] >= 0 && mcyc_b >= 2 * trip_b[i]) ? 1'b0 : 1'b1;
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input int which, input int t0, input int t1);
        if (which == 0) begin
            trip_a[0] = t0;
            trip_a[1] = t1;
        end else begin
            trip_b[0] = t0;
            trip_b[1] = t1;
        end
    endtask

    task automatic wait_valid_a(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge osc);
            if (bus_a.valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Counts negedges with the capacitor low until it rises.
    task automatic count_low_a(output int low_cnt);
        low_cnt = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge osc);
            if (bus_a.capacitor === 1'b1) break;
            low_cnt++;
        end
    endtask

    initial begin
        bit ok;
        int low_cnt;
        int vcnt;
        int prev;

        vecs[0] = '{10,  20,  10,  20,  0, 42};
        vecs[1] = '{5,   -1,  5,   255, 2, 512};
        vecs[2] = '{0,   0,   0,   0,   0, 2};
        vecs[3] = '{-1,  3,   255, 3,   1, 512};
        vecs[4] = '{7,   7,   7,   7,   0, 16};
        vecs[5] = '{255, 254, 255, 254, 0, 512};
        vecs[6] = '{1,   0,   1,   0,   0, 4};
        vecs[7] = '{12,  34,  12,  34,  0, 70};

        frames[0] = '{'{10, 11, 12, 13}, '{20, 20, 20, 24}, 11, 21, 0};
        frames[1] = '{'{0, 0, 0, 4},     '{8, -1, 8, 8},    1,  69, 2};
        frames[2] = '{'{3, 3, 3, 3},     '{2, 2, 2, 2},     3,  2,  0};

        // Reset held with enable high
        reset         = 1'b1;
        bus_a.enable  = 1'b1;
        bus_b.enable  = 1'b0;
        apply_stimulus(0, vecs[0].trip0, vecs[0].trip1);
        repeat (3) @(posedge osc);
        @(negedge osc);
        check_output("reset_capacitor", 32'(bus_a.capacitor), 0);
        check_output("reset_out",       32'(bus_a.out), 0);
        check_output("reset_overrange", 32'(bus_a.overrange), 0);
        check_output("reset_valid",     32'(bus_a.valid), 0);
        check_output("reset_out_b",     32'(bus_b.out), 0);
        reset = 1'b0;

        // IDLE -> DISCHARGE on the first edge, 4 ticks of 2 cycles
        count_low_a(low_cnt);
        check_output("discharge_cycles", low_cnt, 8);

        for (int v = 0; v < 8; v++) begin
            wait_valid_a(ok);
            check_output($sformatf("v%0d_valid_seen", v), 32'(ok), 1);
            check_output($sformatf("v%0d_ch0", v), 32'(bus_a.out[7:0]), vecs[v].exp0);
            check_output($sformatf("v%0d_ch1", v), 32'(bus_a.out[15:8]), vecs[v].exp1);
            check_output($sformatf("v%0d_overrange", v), 32'(bus_a.overrange), vecs[v].exp_ovr);
            check_output($sformatf("v%0d_measure_cycles", v), meas_len_a, vecs[v].exp_len);
            @(negedge osc);
            check_output($sformatf("v%0d_valid_width", v), 32'(bus_a.valid), 0);
            if (v < 7) apply_stimulus(0, vecs[v+1].trip0, vecs[v+1].trip1);
            else       apply_stimulus(0, 30, 30);
        end

        // Drop enable partway through MEASURE
        count_low_a(low_cnt);
        for (int c = 0; c < 100; c++) begin
            if (mcyc_a >= 12) break;
            @(negedge osc);
        end
        vcnt = valid_cnt_a;
        bus_a.enable = 1'b0;
        @(negedge osc);
        check_output("disable_capacitor", 32'(bus_a.capacitor), 0);
        check_output("disable_valid", 32'(bus_a.valid), 0);
        repeat (80) @(negedge osc);
        check_output("disable_no_valid", valid_cnt_a, vcnt);
        check_output("disable_hold_ch0", 32'(bus_a.out[7:0]), 12);
        check_output("disable_hold_ch1", 32'(bus_a.out[15:8]), 34);
        check_output("disable_hold_ovr", 32'(bus_a.overrange), 0);
        check_output("disable_idle_cap", 32'(bus_a.capacitor), 0);

        // Averaging instance: one valid per four conversions
        bus_b.enable = 1'b1;
        for (int f = 0; f < 3; f++) begin
            for (int n = 0; n < 4; n++) begin
                apply_stimulus(1, frames[f].t0[n], frames[f].t1[n]);
                prev = conv_cnt_b;
                ok = 1'b0;
                for (int c = 0; c < 2000; c++) begin
                    @(negedge osc);
                    if (conv_cnt_b > prev) begin
                        ok = 1'b1;
                        break;
                    end
                end
                check_output($sformatf("f%0d_c%0d_done", f, n), 32'(ok), 1);
                if (n < 3) begin
                    check_output($sformatf("f%0d_c%0d_no_valid", f, n), valid_cnt_b, f);
                end else begin
                    check_output($sformatf("f%0d_valid", f), 32'(bus_b.valid), 1);
                    check_output($sformatf("f%0d_valid_count", f), valid_cnt_b, f + 1);
                    check_output($sformatf("f%0d_ch0", f), 32'(bus_b.out[7:0]), frames[f].exp0);
                    check_output($sformatf("f%0d_ch1", f), 32'(bus_b.out[15:8]), frames[f].exp1);
                    check_output($sformatf("f%0d_overrange", f), 32'(bus_b.overrange), frames[f].exp_ovr);
                end
            end
        end
        bus_b.enable = 1'b0;

        // Re-enable from IDLE, then reset in the middle of MEASURE
        apply_stimulus(0, 50, 60);
        bus_a.enable = 1'b1;
        count_low_a(low_cnt);
        check_output("reenable_discharge_cycles", low_cnt, 8);
        repeat (20) @(negedge osc);
        check_output("mid_measure_capacitor", 32'(bus_a.capacitor), 1);
        reset = 1'b1;
        @(negedge osc);
        check_output("midreset_capacitor", 32'(bus_a.capacitor), 0);
        check_output("midreset_out",       32'(bus_a.out), 0);
        check_output("midreset_overrange", 32'(bus_a.overrange), 0);
        check_output("midreset_valid",     32'(bus_a.valid), 0);
        check_output("midreset_out_b",     32'(bus_b.out), 0);
        reset = 1'b0;
        bus_a.enable = 1'b0;
        repeat (2) @(negedge osc);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/slope_adc_mc.md
# slope_adc_mc

Multi-channel single-slope ADC front end that replaces the single-channel capacitor-timing converter. It drives one shared RC charge output, times each channel's comparator trip against a common tick counter, optionally averages 2^AVG_LOG2 conversions per channel, and publishes a frame of results with a one-cycle valid strobe. It sits between the LVDS comparator input primitives, which are instantiated outside this block, and the audio/control-rate consumers running on `osc`.

## Interface
- `CHANNELS`, 1: number of comparator inputs sharing the capacitor drive.
- `WIDTH`, 16: result width; full-scale measure window is 2^WIDTH−1 ticks.
- `TICK_DIV`, 8: `osc` cycles per tick; must be at least 1.
- `DISCHARGE_TICKS`, 65535: ticks with `capacitor` low before each measurement; range 1..2^WIDTH−1.
- `AVG_LOG2`, 0: log2 of the number of conversions averaged per published frame; range 0..4.
- `osc`  in  1: system clock, 49.152 MHz. One clock; reset is synchronous and active-high.
- `reset`  in  1: synchronous, active-high.
- `enable`  in  1: run conversions while high.
- `sense`  in  CHANNELS: raw comparator outputs, asynchronous to `osc`; low means the channel has tripped.
- `capacitor`  out  1: RC drive; high = charge (MEASURE), low otherwise.
- `out`  out  CHANNELS*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH].
- `overrange`  out  CHANNELS: channel failed to trip in at least one conversion of the frame.
- `valid`  out  1: one-cycle pulse when `out` and `overrange` update.

## Operation
- `sense` passes through a 2-flop synchronizer per channel. "Synced sense" means `sense` delayed by 2 `osc` cycles.
- Tick prescaler counts 0..TICK_DIV−1 and asserts `tick` on the terminal count. It is cleared on reset and on IDLE.
- **IDLE**
  - `capacitor`=0.
  - Move to DISCHARGE when `enable`=1. Tick counter cleared.
- **DISCHARGE**
  - `capacitor`=0.
  - After DISCHARGE_TICKS ticks, move to MEASURE. Clear `count` and all per-channel captured flags.
- **MEASURE**
  - `capacitor`=1.
  - On each tick, for every uncaptured channel whose synced sense is 0: capture = `count` and set its flag. Then increment `count`.
  - Leave MEASURE after the tick where all channels are captured, or where `count` was 2^WIDTH−1 (wrap is never reached).
  - Any uncaptured channel at exit gets capture = 2^WIDTH−1 and sets its frame overrange bit.
- **PUBLISH** (1 cycle)
  - acc[i] += capture[i]. Accumulators are WIDTH+AVG_LOG2 bits and cannot overflow.
  - Conversion index increments.
  - On the last conversion of a frame (index wraps at 2^AVG_LOG2):
    - `out`[i] = (acc[i]+capture[i]) >> AVG_LOG2, truncating.
    - `overrange` = the accumulated overrange bits.
    - `valid`=1.
    - Accumulators, overrange bits and index are cleared.
  - Next state is DISCHARGE if `enable`=1, else IDLE.
- `enable`=0 in DISCHARGE or MEASURE:
  - Go to IDLE on the next cycle.
  - Partial conversion, accumulators and index are discarded.
  - `out` and `overrange` hold; no `valid`.
- Simultaneous trip of several channels on one tick: all capture the same `count`.
- A channel that trips and later returns high keeps its first capture.

## Timing
- Reset values:
  - `capacitor`=0, `out`=0, `overrange`=0, `valid`=0.
  - State IDLE; all counters, accumulators and flags 0.
- Reset asserted mid-operation returns everything to reset values on the next edge.
- `sense` to decision latency: 2 cycles of synchronizer, sampled only on tick cycles.
- `valid` is asserted in the cycle after the final MEASURE tick. `out` is stable from that cycle until the next `valid`.
- Conversion period (TICK_DIV=8, WIDTH=16, defaults): ≤ (65535+65535)×8 + a few cycles ≈ 46.9 Hz worst case. Early trips shorten it.
- The `capacitor` edge into MEASURE coincides with the cycle `count` is cleared to 0.

## Structure
- Shared package holds the state encoding (IDLE, DISCHARGE, MEASURE, PUBLISH) and a parameter-range check helper.
- One sub-module, `slope_adc_chan`:
  - Per-channel synchronizer, captured flag, capture register, accumulator and overrange bit.
  - Instantiated CHANNELS times from a generate loop.
- The top level owns the prescaler, `count`, the FSM and output registers.
- The LVDS input primitive stays outside the block.

## Test plan
Bench parameters unless noted: CHANNELS=2, WIDTH=8, TICK_DIV=2, DISCHARGE_TICKS=4, AVG_LOG2=0.
- **Reset:** hold `reset` for 3 cycles with `enable`=1 → `capacitor`=0, `out`=0, `overrange`=00, `valid`=0; DISCHARGE starts after release.
- **Normal trip:** synced sense[0] low from MEASURE tick 10, sense[1] from tick 20 → `valid` pulse once; `out` ch0=10, ch1=20, `overrange`=00; `capacitor` drops the cycle after tick 20.
- **No trip:** sense[1] held high → ch1=255, `overrange`=10; MEASURE lasts exactly 256 ticks (512 cycles).
- **Immediate trip:** both sense low throughout → ch0=ch1=0; MEASURE lasts 1 tick.
- **Averaging:** AVG_LOG2=2, ch0 trips at 10, 11, 12, 13 → a single `valid` after the 4th conversion with ch0=11; no `valid` on conversions 1–3.
- **Disable and reset mid-operation:** drop `enable` at MEASURE tick 5 → IDLE next cycle, `capacitor`=0, no `valid`, `out` unchanged. Re-enable, then assert `reset` mid-MEASURE → all outputs 0.
